// File: rtl/fetch_pkg.sv
// Shared constants and types for the fetch stage.
//   N          : datapath / PC width
//   INSTR_W    : instruction word width
//   OP_W       : opcode field width (instr[OP_HI:OP_LO])
//   NOP_INSTR  : bubble word written into IF/ID on a flush
//   RESET_PC   : default PC after reset
package fetch_pkg;

  localparam int          N         = 64;
  localparam int          INSTR_W   = 32;
  localparam int          OP_W      = 11;
  localparam int          OP_HI     = 31;
  localparam int          OP_LO     = 21;
  localparam logic [31:0] NOP_INSTR = 32'h0;
  localparam logic [63:0] RESET_PC  = 64'h0;

  // What the fetch stage does on the next clock edge.
  typedef enum logic [1:0] {
    ACT_ADVANCE  = 2'd0,
    ACT_STALL    = 2'd1,
    ACT_REDIRECT = 2'd2
  } fetch_act_e;

  // Redirect beats stall beats normal advance.
  function automatic fetch_act_e fetch_action(input logic branch_taken,
                                              input logic stall_F);
    if (branch_taken)  return ACT_REDIRECT;
    else if (stall_F)  return ACT_STALL;
    else               return ACT_ADVANCE;
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Instruction-memory bus between the fetch stage and the memory.
//   imem_addr : word address driven by fetch
//   imem_data : instruction word, combinational read of imem_addr
interface fetch_if #(
  parameter int IMEM_ADDR_W = 6
);
  import fetch_pkg::*;

  logic [IMEM_ADDR_W-1:0] imem_addr;
  logic [INSTR_W-1:0]     imem_data;

  modport master (output imem_addr, input  imem_data);
  modport slave  (input  imem_addr, output imem_data);
endinterface

// File: rtl/fetch_flopre.sv
// flopre: W-bit register with asynchronous reset, synchronous clear and enable.
//   clk, reset : clock, async active-high reset (loads RST_VAL)
//   en         : load d when high
//   clr        : synchronous clear to zero, takes priority over en
//   d, q       : data in / registered out
module flopre #(
  parameter int           W       = 8,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      q <= RST_VAL;
    else if (clr)   q <= '0;
    else if (en)    q <= d;
  end

endmodule

// File: rtl/fetch.sv
// fetch: PC register, PC-next mux / +4 adder and the IF/ID pipeline register.
//   clk, reset     : clock, async active-high reset
//   stall_F        : freeze PC and IF/ID
//   branch_taken   : redirect to branch_target (word aligned), flush IF/ID
//   branch_target  : redirect PC
//   imem           : instruction-memory bus (address out, word in)
//   pc_F           : current fetch PC
//   pc_D, instr_D  : PC and instruction held in IF/ID
//   op_D           : opcode field of instr_D
//   valid_D        : IF/ID holds a real instruction (0 = bubble)
module fetch
  import fetch_pkg::*;
#(
  parameter int           N           = fetch_pkg::N,
  parameter int           IMEM_ADDR_W = 6,
  parameter logic [N-1:0] RESET_PC    = N'(fetch_pkg::RESET_PC)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall_F,
  input  logic                 branch_taken,
  input  logic [N-1:0]         branch_target,
  fetch_if.master              imem,
  output logic [N-1:0]         pc_F,
  output logic [N-1:0]         pc_D,
  output logic [INSTR_W-1:0]   instr_D,
  output logic [OP_W-1:0]      op_D,
  output logic                 valid_D
);

  fetch_act_e     w_act;
  logic [N-1:0]   w_pc_plus4;
  logic [N-1:0]   w_pc_next;
  logic           w_pc_en;
  logic           w_ifid_en;
  logic           w_ifid_clr;

  assign w_act      = fetch_action(branch_taken, stall_F);
  // Adder wraps naturally modulo 2^N.
  assign w_pc_plus4 = pc_F + N'(4);
  // Low two bits of the target are dropped to keep the PC word aligned.
  assign w_pc_next  = (w_act == ACT_REDIRECT) ? (branch_target & ~N'(3)) : w_pc_plus4;
  assign w_pc_en    = (w_act != ACT_STALL);
  assign w_ifid_en  = (w_act == ACT_ADVANCE);
  assign w_ifid_clr = (w_act == ACT_REDIRECT);

  // Word address wraps modulo 2^IMEM_ADDR_W by truncation.
  assign imem.imem_addr = pc_F[IMEM_ADDR_W+1:2];

  // ---- stage F: program counter ----
  flopre #(.W(N), .RST_VAL(RESET_PC)) u_pc (
    .clk(clk), .reset(reset), .en(w_pc_en), .clr(1'b0),
    .d(w_pc_next), .q(pc_F)
  );

  // ---- stage D: IF/ID register (clear on redirect makes a bubble) ----
  flopre #(.W(N), .RST_VAL('0)) u_pc_d (
    .clk(clk), .reset(reset), .en(w_ifid_en), .clr(w_ifid_clr),
    .d(pc_F), .q(pc_D)
  );

  flopre #(.W(INSTR_W), .RST_VAL(NOP_INSTR)) u_instr_d (
    .clk(clk), .reset(reset), .en(w_ifid_en), .clr(w_ifid_clr),
    .d(imem.imem_data), .q(instr_D)
  );

  flopre #(.W(1), .RST_VAL(1'b0)) u_valid_d (
    .clk(clk), .reset(reset), .en(w_ifid_en), .clr(w_ifid_clr),
    .d(1'b1), .q(valid_D)
  );

  assign op_D = instr_D[OP_HI:OP_LO];

endmodule

// File: tb/tb_fetch.sv
module tb_fetch;

  localparam int N  = 64;
  localparam int AW = 6;

  logic           clk = 1'b0;
  logic           reset;
  logic           stall_F;
  logic           branch_taken;
  logic [N-1:0]   branch_target;
  logic [N-1:0]   pc_F, pc_D;
  logic [31:0]    instr_D;
  logic [10:0]    op_D;
  logic           valid_D;

  logic [31:0]    mem [0:63];

  int n_cmp  = 0;
  int n_fail = 0;

  fetch_if #(.IMEM_ADDR_W(AW)) bus ();
  assign bus.imem_data = mem[bus.imem_addr];

  fetch #(.N(N), .IMEM_ADDR_W(AW), .RESET_PC(64'h0)) dut (
    .clk(clk), .reset(reset), .stall_F(stall_F), .branch_taken(branch_taken),
    .branch_target(branch_target), .imem(bus.master), .pc_F(pc_F), .pc_D(pc_D),
    .instr_D(instr_D), .op_D(op_D), .valid_D(valid_D)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the fetch stream as a pair (next PC to fetch,
  // the word currently decoded), updated from the priority rules.
  logic [63:0] m_pc, m_pcD;
  logic [31:0] m_instrD;
  logic        m_validD;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_pc <= 64'h0; m_pcD <= 64'h0; m_instrD <= 32'h0; m_validD <= 1'b0;
    end else if (branch_taken) begin
      m_pc <= branch_target - (branch_target % 4);
      m_pcD <= 64'h0; m_instrD <= 32'h0; m_validD <= 1'b0;
    end else if (!stall_F) begin
      m_pc <= m_pc + 64'd4;
      m_pcD <= m_pc;
      m_instrD <= mem[(m_pc / 4) % 64];
      m_validD <= 1'b1;
    end
  end

  // Compare process: every low phase the outputs are stable.
  always @(negedge clk) begin
    chk("pc_F",      pc_F,          m_pc);
    chk("pc_D",      pc_D,          m_pcD);
    chk("instr_D",   {32'h0, instr_D}, {32'h0, m_instrD});
    chk("op_D",      {53'h0, op_D}, {53'h0, m_instrD / 32'h0020_0000});
    chk("valid_D",   {63'h0, valid_D}, {63'h0, m_validD});
    chk("imem_addr", {58'h0, bus.imem_addr}, (m_pc / 4) % 64);
  end

  initial begin
    for (int k = 0; k < 64; k++) mem[k] = k + 1;
    mem[3] = {11'h7C2, 21'd4};
    reset = 1'b1; stall_F = 1'b0; branch_taken = 1'b0; branch_target = '0;
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    #1;
    chk("lit_rst_pc", pc_F, 64'h0);
    chk("lit_rst_valid", {63'h0, valid_D}, 64'h0);
    chk("lit_rst_instr", {32'h0, instr_D}, 64'h0);

    @(negedge clk); #1;
    chk("lit_pc4", pc_F, 64'd4);
    chk("lit_instr1", {32'h0, instr_D}, 64'd1);
    chk("lit_valid1", {63'h0, valid_D}, 64'd1);
    @(negedge clk); #1;
    chk("lit_pc8", pc_F, 64'd8);
    chk("lit_instr2", {32'h0, instr_D}, 64'd2);

    // Stall three cycles at pc_F = 8.
    stall_F = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("lit_stall_pc", pc_F, 64'd8);
      chk("lit_stall_instr", {32'h0, instr_D}, 64'd2);
      chk("lit_stall_pcD", pc_D, 64'd4);
    end
    stall_F = 1'b0;
    @(negedge clk); #1;
    chk("lit_resume_pc", pc_F, 64'd12);
    chk("lit_resume_instr", {32'h0, instr_D}, 64'd3);
    chk("lit_resume_pcD", pc_D, 64'd8);
    @(negedge clk); #1;
    chk("lit_op7c2", {53'h0, op_D}, 64'h7C2);
    chk("lit_op_valid", {63'h0, valid_D}, 64'd1);
    chk("lit_op_pcD", pc_D, 64'd12);
    chk("lit_pc16", pc_F, 64'd16);

    // Redirect to 0x23 at pc_F = 16.
    branch_taken = 1'b1; branch_target = 64'h23;
    @(negedge clk); branch_taken = 1'b0; #1;
    chk("lit_br_pc", pc_F, 64'h20);
    chk("lit_br_instr", {32'h0, instr_D}, 64'h0);
    chk("lit_br_op", {53'h0, op_D}, 64'h0);
    chk("lit_br_valid", {63'h0, valid_D}, 64'h0);
    @(negedge clk); #1;
    chk("lit_br_word8", {32'h0, instr_D}, 64'd9);
    chk("lit_br_pcD", pc_D, 64'h20);

    // Redirect and stall together.
    branch_taken = 1'b1; stall_F = 1'b1; branch_target = 64'h40;
    @(negedge clk); branch_taken = 1'b0; stall_F = 1'b0; #1;
    chk("lit_brst_pc", pc_F, 64'h40);
    chk("lit_brst_valid", {63'h0, valid_D}, 64'h0);
    chk("lit_brst_instr", {32'h0, instr_D}, 64'h0);

    // PC wrap.
    branch_taken = 1'b1; branch_target = 64'hFFFF_FFFF_FFFF_FFFC;
    @(negedge clk); branch_taken = 1'b0; #1;
    chk("lit_top_pc", pc_F, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("lit_top_addr", {58'h0, bus.imem_addr}, 64'd63);
    @(negedge clk); #1;
    chk("lit_wrap_pc", pc_F, 64'h0);
    chk("lit_wrap_addr", {58'h0, bus.imem_addr}, 64'h0);
    chk("lit_wrap_instr", {32'h0, instr_D}, 64'd64);

    // Reset in the middle of a stall, between clock edges.
    stall_F = 1'b1;
    @(negedge clk); #2; reset = 1'b1; #1;
    chk("lit_async_pc", pc_F, 64'h0);
    chk("lit_async_valid", {63'h0, valid_D}, 64'h0);
    @(negedge clk); @(negedge clk); #1;
    reset = 1'b0; stall_F = 1'b0;
    @(negedge clk); #1;
    chk("lit_restart_pc", pc_F, 64'd4);

    // Randomized phase.
    for (int k = 0; k < 64; k++) mem[k] = $urandom;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk); #1;
      stall_F       = ($urandom_range(0, 99) < 30);
      branch_taken  = ($urandom_range(0, 99) < 10);
      branch_target = {$urandom, $urandom};
      if ($urandom_range(0, 99) < 50) branch_target[63:8] = '0;
      if ($urandom_range(0, 199) == 0) begin
        #1 reset = 1'b1;
        @(negedge clk); #1 reset = 1'b0;
      end
    end
    @(negedge clk); #1;
    stall_F = 1'b0; branch_taken = 1'b0;
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch.md
FETCH -- requirements
Module: fetch

Interface
REQ-001 Parameter N, default 64, datapath and PC width in bits.
REQ-002 Parameter IMEM_ADDR_W, default 6, instruction-memory word-address width (64 words).
REQ-003 Parameter RESET_PC, default 0, PC value loaded on reset.
REQ-004 The block SHALL use one clock and asynchronous active-high reset: `clk  in  1  rising-edge clock`.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 stall_F  in  1  hold request from hazard logic; freezes PC and IF/ID register.
REQ-007 branch_taken  in  1  redirect request; the branch was resolved taken (CBZ/CBNZ) downstream.
REQ-008 branch_target  in  N  redirect PC value.
REQ-009 imem_addr  out  IMEM_ADDR_W  word address to instruction memory, equal to PC[IMEM_ADDR_W+1:2].
REQ-010 imem_data  in  32  instruction word; combinational read of imem_addr in the same cycle.
REQ-011 pc_F  out  N  current fetch PC.
REQ-012 pc_D  out  N  PC of the instruction held in IF/ID.
REQ-013 instr_D  out  32  instruction held in IF/ID.
REQ-014 op_D  out  11  instr_D[31:21], the opcode field driven to maindec.
REQ-015 valid_D  out  1  instr_D holds a real fetched instruction; 0 means bubble.

Function
REQ-016 On each rising clk edge, the block SHALL use the priority branch_taken > stall_F > normal advance.
REQ-017 Normal advance: PC <= PC+4; pc_D <= PC; instr_D <= imem_data; valid_D <= 1.
REQ-018 Redirect: PC <= {branch_target[N-1:2],2'b00}; instr_D <= 32'h0; pc_D <= 0; valid_D <= 0. The flushed word is a bubble, and op_D = 0 decodes to all-zero controls.
REQ-019 Stall (without redirect): PC, pc_D, instr_D and valid_D SHALL hold their values.
REQ-020 Simultaneous branch_taken and stall_F: the redirect SHALL win, the IF/ID register SHALL be flushed, and the stall SHALL be ignored that cycle.
REQ-021 PC arithmetic SHALL be modulo 2^N, so PC = 2^N-4 advances to 0.
REQ-022 imem_addr SHALL wrap modulo 2^IMEM_ADDR_W, with no error indication.
REQ-023 Latency: an instruction at PC p appears on instr_D/op_D exactly one cycle after pc_F = p with no stall or redirect.
REQ-024 op_D SHALL be purely combinational from instr_D, with no extra register.
REQ-025 The first cycle after reset deassertion SHALL present valid_D = 0 and instr_D = 0.
REQ-026 A stall held for k cycles SHALL delay every output by exactly k cycles, with no instruction lost or duplicated.

Reset
REQ-027 When reset is asserted (asynchronously), the block SHALL set PC = RESET_PC, pc_D = 0, instr_D = 0 and valid_D = 0, immediately and regardless of clk.
REQ-028 Reset asserted mid-stall or mid-redirect SHALL override both, and fetch SHALL restart at RESET_PC after deassertion.

Structure
REQ-029 The shared package SHALL hold N, INSTR_W = 32, OP_W = 11, NOP_INSTR = 32'h0, RESET_PC and the opcode-field slice bounds (31:21).
REQ-030 One sub-module, flopre, SHALL be used: a parameterised register with asynchronous reset, enable, and synchronous clear. It SHALL be instantiated for the PC and for each IF/ID field.
REQ-031 The PC-next mux and the +4 adder SHALL be local to fetch, and no memory SHALL be inside the block.

Verification
REQ-032 Reset, then free-run with imem word k = k+1 -> pc_F = 0, 4, 8; instr_D = 0 (valid 0), then 1, 2, 3 on successive cycles.
REQ-033 Fetch with imem word 3 = 11'b111_1100_0010 in the opcode field -> op_D = 0x7C2 with valid_D = 1 one cycle after pc_F = 12.
REQ-034 stall_F high for 3 cycles at pc_F = 8 -> pc_F stays 8, instr_D/pc_D frozen for 3 cycles, then the sequence resumes without a gap.
REQ-035 branch_taken with target 0x23 at pc_F = 16 -> next pc_F = 0x20; instr_D = 0, op_D = 0 and valid_D = 0 for one cycle; then imem word 8.
REQ-036 branch_taken and stall_F together with target 0x40 -> pc_F = 0x40 and IF/ID flushed, with the stall ignored.
REQ-037 PC forced to 2^64-4 via redirect, then one advance -> pc_F = 0 and imem_addr = 0; reset pulsed mid-stall -> pc_F = 0 and valid_D = 0 immediately.
